// File: rtl/ahb_sram_master.sv
// Command-driven AHB-Lite master feeding the sramc slave port.
// Issues SINGLE/INCR word bursts, handles wait states, the 1 KB boundary and two-cycle ERROR responses.
module ahb_sram_master #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int LEN_WIDTH    = 8,
    parameter int HBURST_WIDTH = 3,
    parameter int HTRANS_WIDTH = 2,
    parameter int HSIZE_WIDTH  = 3,
    parameter int HRESP_WIDTH  = 2
) (
    input  logic                    hclk,
    input  logic                    hreset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [LEN_WIDTH-1:0]    cmd_len,
    input  logic                    wdata_valid,
    output logic                    wdata_ready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic                    rdata_valid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    done,
    output logic                    err,
    output logic [ADDR_WIDTH-1:0]   haddr,
    output logic [HTRANS_WIDTH-1:0] htrans,
    output logic                    hwrite,
    output logic [HSIZE_WIDTH-1:0]  hsize,
    output logic [HBURST_WIDTH-1:0] hburst,
    output logic                    hsel,
    output logic [DATA_WIDTH-1:0]   hwdata,
    output logic                    hready,
    input  logic [DATA_WIDTH-1:0]   hrdata,
    input  logic [HRESP_WIDTH-1:0]  hresp,
    input  logic                    hready_resp
);

    localparam logic [HTRANS_WIDTH-1:0] TR_IDLE   = HTRANS_WIDTH'(0);
    localparam logic [HTRANS_WIDTH-1:0] TR_BUSY   = HTRANS_WIDTH'(1);
    localparam logic [HTRANS_WIDTH-1:0] TR_NONSEQ = HTRANS_WIDTH'(2);
    localparam logic [HTRANS_WIDTH-1:0] TR_SEQ    = HTRANS_WIDTH'(3);
    localparam logic [HBURST_WIDTH-1:0] BU_SINGLE = HBURST_WIDTH'(0);
    localparam logic [HBURST_WIDTH-1:0] BU_INCR   = HBURST_WIDTH'(1);
    localparam logic [HRESP_WIDTH-1:0]  RS_OKAY   = HRESP_WIDTH'(0);
    localparam logic [HRESP_WIDTH-1:0]  RS_ERROR  = HRESP_WIDTH'(1);

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_LAST_DATA, S_ERR} state_t;

    state_t                  state;
    logic [HTRANS_WIDTH-1:0] htrans_r;
    logic [LEN_WIDTH:0]      remain;
    logic                    started;
    logic                    dphase;
    logic                    dphase_write;
    logic [DATA_WIDTH-1:0]   wbuf;

    logic                    err_first;
    logic                    accepted;
    logic [LEN_WIDTH:0]      rem_next;
    logic [ADDR_WIDTH-1:0]   next_addr;
    logic                    burst_step;
    logic                    more;
    logic                    issue;
    logic                    cmd_fire;
    logic                    cmd_misaligned;
    logic                    first_issue;

    always_comb begin
        err_first      = dphase && (hresp == RS_ERROR) && !hready_resp;
        accepted       = htrans_r[1];
        rem_next       = remain - (LEN_WIDTH+1)'(accepted);
        next_addr      = accepted ? haddr + ADDR_WIDTH'(4) : haddr;
        burst_step     = (state == S_BURST) && hready_resp;
        more           = (rem_next != '0);
        issue          = burst_step && more && (!hwrite || wdata_valid);
        cmd_fire       = (state == S_IDLE) && cmd_valid;
        cmd_misaligned = (cmd_addr[1:0] != 2'b00);
        first_issue    = cmd_fire && !cmd_misaligned && (!cmd_write || wdata_valid);
        // A write word is taken when its beat is launched; it waits in wbuf until its data phase.
        wdata_ready    = (burst_step && more && hwrite && wdata_valid) ||
                         (first_issue && cmd_write);
        // The pipelined beat is withdrawn combinationally in the first ERROR cycle.
        htrans         = err_first ? TR_IDLE : htrans_r;
        hsel           = (htrans_r != TR_IDLE) || dphase;
        cmd_ready      = (state == S_IDLE);
        hready         = hready_resp;
        hsize          = HSIZE_WIDTH'(3'b010);
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state        <= S_IDLE;
            htrans_r     <= TR_IDLE;
            haddr        <= '0;
            hwrite       <= 1'b0;
            hburst       <= BU_SINGLE;
            hwdata       <= '0;
            wbuf         <= '0;
            remain       <= '0;
            started      <= 1'b0;
            dphase       <= 1'b0;
            dphase_write <= 1'b0;
            rdata_valid  <= 1'b0;
            rdata        <= '0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            done        <= 1'b0;
            err         <= 1'b0;
            rdata_valid <= 1'b0;

            if (hready_resp) begin
                dphase       <= htrans[1];
                dphase_write <= hwrite;
                if (dphase && !dphase_write && (hresp == RS_OKAY)) begin
                    rdata_valid <= 1'b1;
                    rdata       <= hrdata;
                end
            end

            if (wdata_ready)
                wbuf <= wdata;

            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_misaligned) begin
                            done <= 1'b1;
                            err  <= 1'b1;
                        end else begin
                            state    <= S_BURST;
                            haddr    <= cmd_addr;
                            hwrite   <= cmd_write;
                            hburst   <= (cmd_len == '0) ? BU_SINGLE : BU_INCR;
                            remain   <= (LEN_WIDTH+1)'(cmd_len) + (LEN_WIDTH+1)'(1);
                            started  <= first_issue;
                            htrans_r <= first_issue ? TR_NONSEQ : TR_IDLE;
                        end
                    end
                end

                S_BURST: begin
                    if (err_first) begin
                        state    <= S_ERR;
                        htrans_r <= TR_IDLE;
                    end else if (hready_resp) begin
                        remain <= rem_next;
                        if (accepted)
                            hwdata <= wbuf;
                        if (!more) begin
                            state    <= S_LAST_DATA;
                            htrans_r <= TR_IDLE;
                        end else begin
                            haddr <= next_addr;
                            if (issue) begin
                                htrans_r <= (!started || next_addr[9:0] == '0) ? TR_NONSEQ : TR_SEQ;
                                started  <= 1'b1;
                            end else begin
                                htrans_r <= started ? TR_BUSY : TR_IDLE;
                            end
                        end
                    end
                end

                S_LAST_DATA: begin
                    if (err_first) begin
                        state <= S_ERR;
                    end else if (hready_resp) begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                end

                S_ERR: begin
                    if (hready_resp) begin
                        done  <= 1'b1;
                        err   <= 1'b1;
                        state <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_sram_master.sv
// Directed bench for ahb_sram_master; acts as the AHB slave with a small word memory.
module tb_ahb_sram_master;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        wdata_valid, wdata_ready;
    logic [31:0] wdata;
    logic        rdata_valid;
    logic [31:0] rdata;
    logic        done, err;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize, hburst;
    logic        hsel;
    logic [31:0] hwdata;
    logic        hready;
    logic [31:0] hrdata;
    logic [1:0]  hresp;
    logic        hready_resp;

    always #5 hclk = ~hclk;

    ahb_sram_master #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(8),
        .HBURST_WIDTH(3), .HTRANS_WIDTH(2), .HSIZE_WIDTH(3), .HRESP_WIDTH(2)
    ) dut (
        .hclk(hclk), .hreset(hreset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rdata_valid(rdata_valid), .rdata(rdata), .done(done), .err(err),
        .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
        .hburst(hburst), .hsel(hsel), .hwdata(hwdata), .hready(hready),
        .hrdata(hrdata), .hresp(hresp), .hready_resp(hready_resp)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] wq  [0:31];
    logic [31:0] mem [0:1023];
    int          widx;
    logic        dp_valid, dp_write;
    logic [31:0] dp_addr;

    logic [31:0] s_htrans, s_haddr, s_hwrite, s_hburst, s_hsel, s_hwdata, s_hsize, s_hready;
    logic [31:0] s_cmd_ready, s_wready, s_done, s_err, s_rv, s_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive slave/source inputs, sample DUT before the edge, update slave model after it.
    task automatic cyc(input logic hr, input logic [1:0] rsp, input logic wv);
        hready_resp = hr;
        hresp       = rsp;
        wdata_valid = wv;
        wdata       = wq[widx];
        hrdata      = (dp_valid && !dp_write) ? mem[dp_addr[11:2]] : 32'hDEAD_BEEF;
        #1;
        s_htrans = 32'(htrans);   s_haddr  = haddr;           s_hwrite = 32'(hwrite);
        s_hburst = 32'(hburst);   s_hsel   = 32'(hsel);       s_hwdata = hwdata;
        s_hsize  = 32'(hsize);    s_hready = 32'(hready);     s_cmd_ready = 32'(cmd_ready);
        s_wready = 32'(wdata_ready); s_done = 32'(done);      s_err = 32'(err);
        s_rv     = 32'(rdata_valid); s_rdata = rdata;
        @(posedge hclk);
        if (hr) begin
            if (dp_valid && dp_write) mem[dp_addr[11:2]] = s_hwdata;
            dp_valid = s_htrans[1];
            dp_addr  = s_haddr;
            dp_write = s_hwrite[0];
        end
        if (s_wready[0] && wv) widx++;
        #1;
    endtask

    task automatic read_check(input logic [31:0] addr, input logic [7:0] len, input int base,
                              input string tag);
        int got;
        int first;
        got   = 0;
        first = -1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = addr; cmd_len = len;
        cyc(1'b1, 2'b00, 1'b0);
        cmd_valid = 1'b0;
        s_done = 32'd0;
        for (int c = 0; c < 40 && s_done == 32'd0; c++) begin
            cyc(1'b1, 2'b00, 1'b0);
            if (c == 0) begin
                check({tag, " first htrans"}, s_htrans, 32'd2);
                check({tag, " first haddr"}, s_haddr, addr);
                check({tag, " hburst"}, s_hburst, (len == 8'd0) ? 32'd0 : 32'd1);
            end
            if (s_rv[0]) begin
                if (first < 0) first = c;
                check({tag, " rdata"}, s_rdata, wq[base + got]);
                got++;
            end
        end
        check({tag, " done seen"}, s_done, 32'd1);
        check({tag, " beats"}, 32'(got), 32'(len) + 32'd1);
        check({tag, " latency"}, (first >= 2) ? 32'd1 : 32'd0, 32'd1);
        cyc(1'b1, 2'b00, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_tr [0:3];
        logic [31:0] exp_ad [0:3];
        hreset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wdata_valid = 1'b0; wdata = '0; hrdata = '0; hresp = 2'b00; hready_resp = 1'b1;
        for (int i = 0; i < 32; i++) wq[i] = 32'hC0DE_0000 + 32'(i) * 32'h0001_1111;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        widx = 0; dp_valid = 1'b0; dp_write = 1'b0; dp_addr = '0;
        @(posedge hclk); #1;

        // Reset state
        cyc(1'b1, 2'b00, 1'b0);
        cyc(1'b1, 2'b00, 1'b0);
        hreset = 1'b0;
        cyc(1'b0, 2'b00, 1'b0);
        check("rst htrans", s_htrans, 32'd0);
        check("rst haddr", s_haddr, 32'd0);
        check("rst hwrite", s_hwrite, 32'd0);
        check("rst hsel", s_hsel, 32'd0);
        check("rst hburst", s_hburst, 32'd0);
        check("rst hwdata", s_hwdata, 32'd0);
        check("rst cmd_ready", s_cmd_ready, 32'd1);
        check("rst wready", s_wready, 32'd0);
        check("rst rvalid", s_rv, 32'd0);
        check("rst done", s_done, 32'd0);
        check("rst err", s_err, 32'd0);
        check("rst hsize", s_hsize, 32'd2);
        check("hready follows low", s_hready, 32'd0);

        // 4-beat write at 0x100, data always available
        widx = 0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h100; cmd_len = 8'd3;
        cyc(1'b1, 2'b00, 1'b1);
        check("w4 accept cmd_ready", s_cmd_ready, 32'd1);
        check("w4 accept wready", s_wready, 32'd1);
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 2'b00, 1'b1);
            check("w4 htrans", s_htrans, (i == 0) ? 32'd2 : 32'd3);
            check("w4 haddr", s_haddr, 32'h100 + 32'(4 * i));
            check("w4 hburst", s_hburst, 32'd1);
            check("w4 hwrite", s_hwrite, 32'd1);
            check("w4 wready", s_wready, (i < 3) ? 32'd1 : 32'd0);
            if (i > 0) check("w4 hwdata", s_hwdata, wq[i - 1]);
        end
        cyc(1'b1, 2'b00, 1'b1);
        check("w4 last htrans", s_htrans, 32'd0);
        check("w4 last hwdata", s_hwdata, wq[3]);
        check("w4 last cmd_ready", s_cmd_ready, 32'd0);
        check("w4 last done", s_done, 32'd0);
        cyc(1'b1, 2'b00, 1'b0);
        check("w4 done", s_done, 32'd1);
        check("w4 err", s_err, 32'd0);
        check("w4 done cmd_ready", s_cmd_ready, 32'd1);
        cyc(1'b1, 2'b00, 1'b0);
        check("w4 done pulse", s_done, 32'd0);

        // Readback and a SINGLE read
        read_check(32'h100, 8'd3, 0, "r4");
        read_check(32'h104, 8'd0, 1, "r1");

        // Write with a wait state on beat 2 and data gap before beat 3
        widx = 4;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h200; cmd_len = 8'd3;
        cyc(1'b1, 2'b00, 1'b1);
        check("wg accept wready", s_wready, 32'd1);
        cmd_valid = 1'b0;
        cyc(1'b1, 2'b00, 1'b1);
        check("wg c1 htrans", s_htrans, 32'd2);
        check("wg c1 wready", s_wready, 32'd1);
        cyc(1'b0, 2'b00, 1'b1);
        check("wg wait htrans", s_htrans, 32'd3);
        check("wg wait haddr", s_haddr, 32'h204);
        check("wg wait hwdata", s_hwdata, wq[4]);
        check("wg wait wready", s_wready, 32'd0);
        cyc(1'b1, 2'b00, 1'b0);
        check("wg c3 htrans", s_htrans, 32'd3);
        check("wg c3 haddr", s_haddr, 32'h204);
        check("wg c3 hburst", s_hburst, 32'd1);
        cyc(1'b1, 2'b00, 1'b0);
        check("wg busy1 htrans", s_htrans, 32'd1);
        check("wg busy1 haddr", s_haddr, 32'h208);
        check("wg busy1 hwdata", s_hwdata, wq[5]);
        cyc(1'b1, 2'b00, 1'b1);
        check("wg busy2 htrans", s_htrans, 32'd1);
        check("wg busy2 haddr", s_haddr, 32'h208);
        check("wg busy2 wready", s_wready, 32'd1);
        cyc(1'b1, 2'b00, 1'b1);
        check("wg b3 htrans", s_htrans, 32'd3);
        check("wg b3 haddr", s_haddr, 32'h208);
        cyc(1'b1, 2'b00, 1'b1);
        check("wg b4 htrans", s_htrans, 32'd3);
        check("wg b4 haddr", s_haddr, 32'h20C);
        check("wg b4 hwdata", s_hwdata, wq[6]);
        check("wg b4 wready", s_wready, 32'd0);
        cyc(1'b1, 2'b00, 1'b0);
        check("wg last hwdata", s_hwdata, wq[7]);
        cyc(1'b1, 2'b00, 1'b0);
        check("wg done", s_done, 32'd1);
        check("wg err", s_err, 32'd0);
        cyc(1'b1, 2'b00, 1'b0);
        read_check(32'h200, 8'd3, 4, "rg");

        // 1 KB boundary crossing
        exp_tr[0] = 32'd2; exp_tr[1] = 32'd3; exp_tr[2] = 32'd2; exp_tr[3] = 32'd3;
        exp_ad[0] = 32'h3F8; exp_ad[1] = 32'h3FC; exp_ad[2] = 32'h400; exp_ad[3] = 32'h404;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h3F8; cmd_len = 8'd3;
        cyc(1'b1, 2'b00, 1'b0);
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 2'b00, 1'b0);
            check("kb htrans", s_htrans, exp_tr[i]);
            check("kb haddr", s_haddr, exp_ad[i]);
        end
        cyc(1'b1, 2'b00, 1'b0);
        cyc(1'b1, 2'b00, 1'b0);
        check("kb done", s_done, 32'd1);
        cyc(1'b1, 2'b00, 1'b0);

        // ERROR response on beat 2 of an 8-beat write
        widx = 8;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h300; cmd_len = 8'd7;
        cyc(1'b1, 2'b00, 1'b1);
        cmd_valid = 1'b0;
        cyc(1'b1, 2'b00, 1'b1);
        check("er b1 htrans", s_htrans, 32'd2);
        cyc(1'b1, 2'b00, 1'b1);
        check("er b2 haddr", s_haddr, 32'h304);
        check("er b2 wready", s_wready, 32'd1);
        cyc(1'b0, 2'b01, 1'b1);
        check("er first htrans", s_htrans, 32'd0);
        check("er first wready", s_wready, 32'd0);
        check("er first hsel", s_hsel, 32'd1);
        cyc(1'b1, 2'b01, 1'b1);
        check("er second htrans", s_htrans, 32'd0);
        check("er second wready", s_wready, 32'd0);
        cyc(1'b1, 2'b00, 1'b1);
        check("er done", s_done, 32'd1);
        check("er err", s_err, 32'd1);
        check("er cmd_ready", s_cmd_ready, 32'd1);
        check("er idle htrans", s_htrans, 32'd0);
        check("er idle wready", s_wready, 32'd0);
        cyc(1'b1, 2'b00, 1'b0);
        check("er done pulse", s_done, 32'd0);
        check("er hsel", s_hsel, 32'd0);

        // Misaligned command
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h102; cmd_len = 8'd3;
        cyc(1'b1, 2'b00, 1'b1);
        check("mis wready", s_wready, 32'd0);
        cmd_valid = 1'b0;
        cyc(1'b1, 2'b00, 1'b0);
        check("mis done", s_done, 32'd1);
        check("mis err", s_err, 32'd1);
        check("mis htrans", s_htrans, 32'd0);
        check("mis hsel", s_hsel, 32'd0);
        cyc(1'b1, 2'b00, 1'b0);
        check("mis done pulse", s_done, 32'd0);
        check("mis htrans later", s_htrans, 32'd0);

        // Reset in the middle of a burst
        widx = 12;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h100; cmd_len = 8'd3;
        cyc(1'b1, 2'b00, 1'b1);
        cmd_valid = 1'b0;
        cyc(1'b1, 2'b00, 1'b1);
        cyc(1'b1, 2'b00, 1'b1);
        check("mr busy htrans", s_htrans, 32'd3);
        hreset = 1'b1;
        cyc(1'b1, 2'b00, 1'b1);
        hreset = 1'b0;
        dp_valid = 1'b0;
        cyc(1'b1, 2'b00, 1'b0);
        check("mr htrans", s_htrans, 32'd0);
        check("mr haddr", s_haddr, 32'd0);
        check("mr hwrite", s_hwrite, 32'd0);
        check("mr hsel", s_hsel, 32'd0);
        check("mr hburst", s_hburst, 32'd0);
        check("mr hwdata", s_hwdata, 32'd0);
        check("mr cmd_ready", s_cmd_ready, 32'd1);
        check("mr done", s_done, 32'd0);
        check("mr err", s_err, 32'd0);
        cyc(1'b1, 2'b00, 1'b0);
        check("mr done later", s_done, 32'd0);
        check("mr htrans later", s_htrans, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
